// File: rtl/yuv_pkg.sv
// Shared constants, latency figures and helpers for the YUV422 -> RGB display path.
// Defining CHROMA_AVG_EN lengthens the chroma stage for interpolated odd-pixel chroma.
package yuv_pkg;

  localparam logic [7:0] Y_OFS = 8'd16;
  localparam logic [7:0] C_OFS = 8'd128;

  // Q8 BT.601 studio-range coefficients
  localparam logic signed [11:0] K_Y  = 12'sd298;
  localparam logic signed [11:0] K_RV = 12'sd409;
  localparam logic signed [11:0] K_GU = 12'sd100;
  localparam logic signed [11:0] K_GV = 12'sd208;
  localparam logic signed [11:0] K_BU = 12'sd516;

  localparam int CSC_LAT = 3;
`ifdef CHROMA_AVG_EN
  localparam int CHROMA_LAT = 4;
`else
  localparam int CHROMA_LAT = 2;
`endif
  localparam int LAT = CHROMA_LAT + CSC_LAT;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

  function automatic logic [7:0] clamp8(input logic signed [19:0] v);
    if (v < 0)              return 8'd0;
    else if (v > 20'sd255)  return 8'd255;
    else                    return v[7:0];
  endfunction

  function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b} + 9'd1;
    return s[8:1];
  endfunction

endpackage

// File: rtl/ycbcr_to_rgb_csc.sv
// Three-stage BT.601 YCbCr -> RGB converter: offset+multiply, sum, round+clamp.
module ycbcr_to_rgb_csc
  import yuv_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] y_i,
  input  logic [7:0] cb_i,
  input  logic [7:0] cr_i,
  output logic [7:0] r_o,
  output logic [7:0] g_o,
  output logic [7:0] b_o
);

  logic signed [9:0]  dy, du, dv;
  logic signed [19:0] py_q, prv_q, pgu_q, pgv_q, pbu_q;
  logic signed [19:0] sr_q, sg_q, sb_q;
  logic [7:0]         r_q, g_q, b_q;

  assign dy = signed'({2'b00, y_i})  - signed'({2'b00, Y_OFS});
  assign du = signed'({2'b00, cb_i}) - signed'({2'b00, C_OFS});
  assign dv = signed'({2'b00, cr_i}) - signed'({2'b00, C_OFS});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      py_q  <= '0;
      prv_q <= '0;
      pgu_q <= '0;
      pgv_q <= '0;
      pbu_q <= '0;
      sr_q  <= '0;
      sg_q  <= '0;
      sb_q  <= '0;
      r_q   <= '0;
      g_q   <= '0;
      b_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments make each stage consume the previous stage's old value.
      py_q  <= 20'(K_Y)  * 20'(dy);
      prv_q <= 20'(K_RV) * 20'(dv);
      pgu_q <= 20'(K_GU) * 20'(du);
      pgv_q <= 20'(K_GV) * 20'(dv);
      pbu_q <= 20'(K_BU) * 20'(du);

      sr_q  <= py_q + prv_q;
      sg_q  <= py_q - pgu_q - pgv_q;
      sb_q  <= py_q + pbu_q;

      r_q   <= clamp8((sr_q + 20'sd128) >>> 8);
      g_q   <= clamp8((sg_q + 20'sd128) >>> 8);
      b_q   <= clamp8((sb_q + 20'sd128) >>> 8);
    end
  end

  assign r_o = r_q;
  assign g_o = g_q;
  assign b_o = b_q;

endmodule

// File: rtl/my_yuv422_to_rgb.sv
// 4:2:2 Y/C to 8-bit RGB: line-phase tracking, 4:4:4 chroma rebuild, CSC and matched sync delay.
// CHROMA_AVG_EN selects interpolated odd-pixel chroma (LAT 7) instead of replication (LAT 5).
module my_yuv422_to_rgb
  import yuv_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_hs,
  input  logic       i_vs,
  input  logic       i_de,
  input  logic [7:0] i_y,
  input  logic [7:0] i_c,
  output logic       o_hs,
  output logic       o_vs,
  output logic       o_de,
  output logic [7:0] o_r,
  output logic [7:0] o_g,
  output logic [7:0] o_b
);

  logic       phase_q;  // set when the next DE pixel of the line is odd
  logic       s1_de_q, s1_odd_q;
  logic [7:0] s1_y_q, s1_c_q;
  logic [7:0] hold_cb_q, hold_cr_q;
  logic [7:0] s2_y_q, s2_cb_q, s2_cr_q;
  logic [7:0] pair_cr, s2_cb_d, s2_cr_d;
  logic [7:0] ch_y, ch_cb, ch_cr;
  logic [7:0] csc_r, csc_g, csc_b;
  sync_t      sync_q [LAT];

  // An even pixel in s1 finds its Cr partner on the live input, unless the line ended.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the block infers a latch.
    pair_cr = C_OFS;
    if (i_de) pair_cr = i_c;
    s2_cb_d = s1_c_q;
    s2_cr_d = pair_cr;
    if (s1_odd_q) begin
      s2_cb_d = hold_cb_q;
      s2_cr_d = hold_cr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= 1'b0;
      s1_de_q   <= 1'b0;
      s1_odd_q  <= 1'b0;
      s1_y_q    <= '0;
      s1_c_q    <= '0;
      hold_cb_q <= C_OFS;
      hold_cr_q <= C_OFS;
      s2_y_q    <= '0;
      s2_cb_q   <= '0;
      s2_cr_q   <= '0;
    end else begin
      phase_q  <= i_de & ~phase_q;
      s1_de_q  <= i_de;
      s1_odd_q <= phase_q;
      s1_y_q   <= i_y;
      s1_c_q   <= i_c;
      if (s1_de_q && !s1_odd_q) begin
        hold_cb_q <= s1_c_q;
        hold_cr_q <= pair_cr;
      end
      s2_y_q  <= s1_y_q;
      s2_cb_q <= s2_cb_d;
      s2_cr_q <= s2_cr_d;
    end
  end

`ifdef CHROMA_AVG_EN
  logic       s2_de_q, s2_odd_q, s3_de_q, s3_odd_q;
  logic [7:0] s3_y_q, s3_cb_q, s3_cr_q;
  logic [7:0] s4_y_q, s4_cb_q, s4_cr_q;
  logic [7:0] s4_cb_d, s4_cr_d;

  // Odd pixel in s3 blends its own pair with the following pair, now sitting in s2.
  always_comb begin
    s4_cb_d = s3_cb_q;
    s4_cr_d = s3_cr_q;
    if (s3_de_q && s3_odd_q && s2_de_q && !s2_odd_q) begin
      s4_cb_d = avg8(s3_cb_q, s2_cb_q);
      s4_cr_d = avg8(s3_cr_q, s2_cr_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_de_q  <= 1'b0;
      s2_odd_q <= 1'b0;
      s3_de_q  <= 1'b0;
      s3_odd_q <= 1'b0;
      s3_y_q   <= '0;
      s3_cb_q  <= '0;
      s3_cr_q  <= '0;
      s4_y_q   <= '0;
      s4_cb_q  <= '0;
      s4_cr_q  <= '0;
    end else begin
      s2_de_q  <= s1_de_q;
      s2_odd_q <= s1_odd_q;
      s3_de_q  <= s2_de_q;
      s3_odd_q <= s2_odd_q;
      s3_y_q   <= s2_y_q;
      s3_cb_q  <= s2_cb_q;
      s3_cr_q  <= s2_cr_q;
      s4_y_q   <= s3_y_q;
      s4_cb_q  <= s4_cb_d;
      s4_cr_q  <= s4_cr_d;
    end
  end

  assign ch_y  = s4_y_q;
  assign ch_cb = s4_cb_q;
  assign ch_cr = s4_cr_q;
`else
  assign ch_y  = s2_y_q;
  assign ch_cb = s2_cb_q;
  assign ch_cr = s2_cr_q;
`endif

  ycbcr_to_rgb_csc u_csc (
    .clk   (clk),
    .rst_n (rst_n),
    .y_i   (ch_y),
    .cb_i  (ch_cb),
    .cr_i  (ch_cr),
    .r_o   (csc_r),
    .g_o   (csc_g),
    .b_o   (csc_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the delay line is small flop storage, so it is reset like any other register.
      for (int i = 0; i < LAT; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {i_hs, i_vs, i_de};
      for (int i = 1; i < LAT; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign o_hs = sync_q[LAT-1].hs;
  assign o_vs = sync_q[LAT-1].vs;
  assign o_de = sync_q[LAT-1].de;
  assign o_r  = o_de ? csc_r : 8'd0;
  assign o_g  = o_de ? csc_g : 8'd0;
  assign o_b  = o_de ? csc_b : 8'd0;

endmodule

// File: tb/tb_my_yuv422_to_rgb.sv
// Self-checking bench for my_yuv422_to_rgb against a pixel-level BT.601 reference model.
`timescale 1ns/1ps
module tb_my_yuv422_to_rgb;

`ifdef CHROMA_AVG_EN
  localparam int LAT = 7;
  localparam bit AVG = 1'b1;
`else
  localparam int LAT = 5;
  localparam bit AVG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_hs = 1'b0, i_vs = 1'b0, i_de = 1'b0;
  logic [7:0] i_y = '0, i_c = '0;
  logic       o_hs, o_vs, o_de;
  logic [7:0] o_r, o_g, o_b;

  always #5 clk = ~clk;

  my_yuv422_to_rgb dut (
    .clk(clk), .rst_n(rst_n),
    .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de), .i_y(i_y), .i_c(i_c),
    .o_hs(o_hs), .o_vs(o_vs), .o_de(o_de), .o_r(o_r), .o_g(o_g), .o_b(o_b)
  );

  typedef struct {
    bit hs;
    bit vs;
    bit de;
    int y;
    int c;
  } stim_t;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } obs_t;

  stim_t stim[$];
  obs_t  cap[$];
  obs_t  exp_q[$];
  int    checks = 0;
  int    failures = 0;

  // ---------------- reference model ----------------
  function automatic int clamp(int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction

  function automatic obs_t pix_rgb(int y, int cb, int cr);
    obs_t o;
    int dy = y - 16;
    int du = cb - 128;
    int dv = cr - 128;
    o = '0;
    o.r = 8'(clamp((298 * dy + 409 * dv + 128) >>> 8));
    o.g = 8'(clamp((298 * dy - 100 * du - 208 * dv + 128) >>> 8));
    o.b = 8'(clamp((298 * dy + 516 * du + 128) >>> 8));
    return o;
  endfunction

  function automatic void build_expected();
    int idx = 0;
    int pcb = 128, pcr = 128;
    int n = stim.size();
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      obs_t e;
      int cb, cr;
      e = '0;
      if (stim[i].de) begin
        idx = (i > 0 && stim[i-1].de) ? idx + 1 : 0;
        if (idx % 2 == 0) begin
          pcb = stim[i].c;
          pcr = (i + 1 < n && stim[i+1].de) ? stim[i+1].c : 128;
          cb = pcb;
          cr = pcr;
        end else begin
          cb = pcb;
          cr = pcr;
          if (AVG && i + 1 < n && stim[i+1].de) begin
            int ncb = stim[i+1].c;
            int ncr = (i + 2 < n && stim[i+2].de) ? stim[i+2].c : 128;
            cb = (pcb + ncb + 1) / 2;
            cr = (pcr + ncr + 1) / 2;
          end
        end
        e = pix_rgb(stim[i].y, cb, cr);
      end
      e.hs = stim[i].hs;
      e.vs = stim[i].vs;
      e.de = stim[i].de;
      exp_q.push_back(e);
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic void push(bit de, int y, int c, bit hs = 1'b0, bit vs = 1'b0);
    stim_t s;
    s.hs = hs; s.vs = vs; s.de = de; s.y = y; s.c = c;
    stim.push_back(s);
  endfunction

  function automatic void push_idle(int n, bit hs = 1'b0, bit vs = 1'b0);
    for (int i = 0; i < n; i++) push(1'b0, 0, 0, hs, vs);
  endfunction

  task automatic drive_and_capture();
    cap.delete();
    foreach (stim[i]) begin
      @(negedge clk);
      i_hs = stim[i].hs;
      i_vs = stim[i].vs;
      i_de = stim[i].de;
      i_y  = 8'(stim[i].y);
      i_c  = 8'(stim[i].c);
      @(posedge clk);
      #1;
      cap.push_back({o_hs, o_vs, o_de, o_r, o_g, o_b});
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      i_hs = 1'b1; i_vs = 1'b1; i_de = 1'b1; i_y = 8'd235; i_c = 8'd128;
      @(posedge clk);
      #1;
      checks++;
      if ({o_hs, o_vs, o_de, o_r, o_g, o_b} !== 27'd0) begin
        failures++;
        $display("FAIL reset_hold[%0d]: got %h expected 0", k, {o_hs, o_vs, o_de, o_r, o_g, o_b});
      end
    end
    @(negedge clk);
    i_hs = 1'b0; i_vs = 1'b0; i_de = 1'b0; i_y = '0; i_c = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_white_black();
    stim.delete();
    push_idle(2, 1'b1);
    for (int k = 0; k < 8; k++) push(1'b1, 235, 128);
    push_idle(3, 1'b1);
    for (int k = 0; k < 8; k++) push(1'b1, 16, 128);
    push_idle(LAT + 1);
    build_expected();
    drive_and_capture();
    for (int i = 0; i + LAT - 1 < cap.size(); i++) begin
      checks++;
      if (cap[i+LAT-1] !== exp_q[i]) begin
        failures++;
        $display("FAIL white_black[%0d]: got %h expected %h", i, cap[i+LAT-1], exp_q[i]);
      end
    end
  endtask

  task automatic test_red_pair();
    stim.delete();
    push_idle(2);
    push(1'b1, 81, 90);
    push(1'b1, 81, 240);
    push_idle(LAT + 1);
    build_expected();
    drive_and_capture();
    for (int i = 0; i + LAT - 1 < cap.size(); i++) begin
      checks++;
      if (cap[i+LAT-1] !== exp_q[i]) begin
        failures++;
        $display("FAIL red_pair[%0d]: got %h expected %h", i, cap[i+LAT-1], exp_q[i]);
      end
    end
    for (int p = 2; p < 4; p++) begin
      checks++;
      if ({cap[p+LAT-1].r, cap[p+LAT-1].g, cap[p+LAT-1].b} !== 24'hFF0000) begin
        failures++;
        $display("FAIL red_pair_rgb[%0d]: got %h expected ff0000", p,
                 {cap[p+LAT-1].r, cap[p+LAT-1].g, cap[p+LAT-1].b});
      end
    end
  endtask

  task automatic test_clamp();
    stim.delete();
    push_idle(2);
    push(1'b1, 255, 128);
    push(1'b1, 255, 255);
    push_idle(2, 1'b1, 1'b1);
    push(1'b1, 0, 128);
    push(1'b1, 0, 128);
    push_idle(LAT + 1);
    build_expected();
    drive_and_capture();
    for (int i = 0; i + LAT - 1 < cap.size(); i++) begin
      checks++;
      if (cap[i+LAT-1] !== exp_q[i]) begin
        failures++;
        $display("FAIL clamp[%0d]: got %h expected %h", i, cap[i+LAT-1], exp_q[i]);
      end
    end
  endtask

  task automatic test_odd_line();
    stim.delete();
    push_idle(2);
    for (int k = 0; k < 5; k++) push(1'b1, 60 + 30 * k, (k % 2 == 0) ? 90 : 240);
    push_idle(3, 1'b1);
    push(1'b1, 120, 200);
    push(1'b1, 140, 70);
    push(1'b1, 160, 50);
    push(1'b1, 180, 180);
    push_idle(LAT + 1);
    build_expected();
    drive_and_capture();
    for (int i = 0; i + LAT - 1 < cap.size(); i++) begin
      checks++;
      if (cap[i+LAT-1] !== exp_q[i]) begin
        failures++;
        $display("FAIL odd_line[%0d]: got %h expected %h", i, cap[i+LAT-1], exp_q[i]);
      end
    end
  endtask

  task automatic test_chroma_interp();
    stim.delete();
    push_idle(2);
    push(1'b1, 128, 100);
    push(1'b1, 128, 200);
    push(1'b1, 128, 140);
    push(1'b1, 128, 60);
    push_idle(LAT + 1);
    build_expected();
    drive_and_capture();
    for (int i = 0; i + LAT - 1 < cap.size(); i++) begin
      checks++;
      if (cap[i+LAT-1] !== exp_q[i]) begin
        failures++;
        $display("FAIL chroma_interp[%0d]: got %h expected %h", i, cap[i+LAT-1], exp_q[i]);
      end
    end
  endtask

  task automatic test_random_lines();
    stim.delete();
    push_idle(2);
    for (int l = 0; l < 8; l++) begin
      int len = $urandom_range(1, 12);
      int gap = $urandom_range(1, 3);
      bit vs  = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < len; k++)
        push(1'b1, $urandom_range(0, 255), $urandom_range(0, 255), 1'b0, vs);
      push_idle(gap, 1'b1, vs);
    end
    push_idle(LAT + 1);
    build_expected();
    drive_and_capture();
    for (int i = 0; i + LAT - 1 < cap.size(); i++) begin
      checks++;
      if (cap[i+LAT-1] !== exp_q[i]) begin
        failures++;
        $display("FAIL random_lines[%0d]: got %h expected %h", i, cap[i+LAT-1], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_midline();
    for (int k = 0; k < LAT + 3; k++) begin
      @(negedge clk);
      i_hs = 1'b0; i_vs = 1'b0; i_de = 1'b1; i_y = 8'd235; i_c = 8'd128;
      @(posedge clk);
    end
    #1;
    checks++;
    if (o_de !== 1'b1 || o_r !== 8'd255) begin
      failures++;
      $display("FAIL pre_reset_white: got de=%0b r=%0d expected de=1 r=255", o_de, o_r);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({o_hs, o_vs, o_de, o_r, o_g, o_b} !== 27'd0) begin
      failures++;
      $display("FAIL reset_async: got %h expected 0", {o_hs, o_vs, o_de, o_r, o_g, o_b});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    i_de = 1'b0; i_y = '0; i_c = '0;
    rst_n = 1'b1;
    stim.delete();
    push_idle(2);
    for (int k = 0; k < 7; k++) push(1'b1, $urandom_range(16, 235), $urandom_range(16, 240));
    push_idle(LAT + 1);
    build_expected();
    drive_and_capture();
    for (int i = 0; i + LAT - 1 < cap.size(); i++) begin
      checks++;
      if (cap[i+LAT-1] !== exp_q[i]) begin
        failures++;
        $display("FAIL post_reset_line[%0d]: got %h expected %h", i, cap[i+LAT-1], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_white_black();
    test_red_pair();
    test_clamp();
    test_odd_line();
    test_chroma_interp();
    test_random_lines();
    test_reset_midline();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
